// File: rtl/tt_sweep_checker.sv
// Sweeps a 3-input logic block through rows 000..111. Each row is held for a settle
// window before the block's output is sampled; the captured table is then graded.
//
// state  | meaning
// IDLE   | waiting for start
// APPLY  | current row driven, settle counter running
// SAMPLE | one cycle; dut_out captured on the exiting edge
// DONE   | result held, inputs parked at 111
module tt_sweep_checker #(
    parameter logic [7:0] TRUTH_TABLE = 8'h60,
    parameter int         SETTLE      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    input  logic       dut_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] observed,
    output logic [3:0] mismatch_count,
    output logic       fail_valid,
    output logic [2:0] first_fail_row
);

    typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

    localparam logic [7:0] TT       = TRUTH_TABLE;
    localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

    state_t     state, state_nxt;
    logic [2:0] row;
    logic [3:0] settle_cnt;
    logic [2:0] stim;
    logic [2:0] bit_idx;
    logic [7:0] observed_nxt;
    logic       sample_bad;

    assign {in1, in2, in3} = stim;

    // Row r lives at bit 7-r, so row 000 is the table MSB.
    assign bit_idx    = 3'd7 - row;
    assign sample_bad = (dut_out != TT[bit_idx]);

    always_comb begin
        observed_nxt          = observed;
        observed_nxt[bit_idx] = dut_out;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = APPLY;
            APPLY:      if (settle_cnt == CNT_LAST) state_nxt = SAMPLE;
            SAMPLE:     state_nxt = (row == 3'd7) ? DONE : APPLY;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row            <= '0;
            settle_cnt     <= '0;
            stim           <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            observed       <= '0;
            mismatch_count <= '0;
            fail_valid     <= 1'b0;
            first_fail_row <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        row            <= '0;
                        settle_cnt     <= '0;
                        stim           <= '0;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        observed       <= '0;
                        mismatch_count <= '0;
                        fail_valid     <= 1'b0;
                        first_fail_row <= '0;
                    end
                end
                APPLY: begin
                    settle_cnt <= settle_cnt + 4'd1;
                end
                SAMPLE: begin
                    observed <= observed_nxt;
                    if (sample_bad) begin
                        mismatch_count <= mismatch_count + 4'd1;
                        if (!fail_valid) begin
                            fail_valid     <= 1'b1;
                            first_fail_row <= row;
                        end
                    end
                    // Next row goes onto the pins on the same edge as the sample,
                    // giving every row SETTLE+1 driven cycles.
                    if (row == 3'd7) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                        pass <= (observed_nxt == TT);
                    end else begin
                        row        <= row + 3'd1;
                        stim       <= row + 3'd1;
                        settle_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Directed bench for tt_sweep_checker: behavioural logic-block models are swept and
// the graded results and edge timing are compared against hand-computed values.
module tb_tt_sweep_checker;

    logic       clk = 1'b0;
    logic       reset, start;
    logic       in1, in2, in3, dut_out;
    logic       busy, done, pass, fail_valid;
    logic [7:0] observed;
    logic [3:0] mismatch_count;
    logic [2:0] first_fail_row;

    logic       b_in1, b_in2, b_in3, b_dut_out;
    logic       b_busy, b_done, b_pass, b_fail_valid;
    logic [7:0] b_observed;
    logic [3:0] b_mismatch_count;
    logic [2:0] b_first_fail_row;

    int mode;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tt_sweep_checker #(.TRUTH_TABLE(8'h60), .SETTLE(4)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in1(in1), .in2(in2), .in3(in3), .dut_out(dut_out),
        .busy(busy), .done(done), .pass(pass), .observed(observed),
        .mismatch_count(mismatch_count), .fail_valid(fail_valid),
        .first_fail_row(first_fail_row)
    );

    tt_sweep_checker #(.TRUTH_TABLE(8'h60), .SETTLE(1)) dut_s1 (
        .clk(clk), .reset(reset), .start(start),
        .in1(b_in1), .in2(b_in2), .in3(b_in3), .dut_out(b_dut_out),
        .busy(b_busy), .done(b_done), .pass(b_pass), .observed(b_observed),
        .mismatch_count(b_mismatch_count), .fail_valid(b_fail_valid),
        .first_fail_row(b_first_fail_row)
    );

    // Logic-block models: 0 ideal, 1 stuck-at-0, 2 inverted, 3 out=in1.
    always_comb begin
        logic [2:0] r;
        r = {in1, in2, in3};
        case (mode)
            1:       dut_out = 1'b0;
            2:       dut_out = !(r == 3'd1 || r == 3'd2);
            3:       dut_out = in1;
            default: dut_out = (r == 3'd1 || r == 3'd2);
        endcase
    end
    assign b_dut_out = ({b_in1, b_in2, b_in3} == 3'd1) || ({b_in1, b_in2, b_in3} == 3'd2);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulses start, then counts edges until done. Optionally pulses start again
    // at edge restart_at. Tracks in1 toggles for the ordering test.
    task automatic run_sweep(input int restart_at, output int done_edge,
                             output int in1_toggles, output int in1_last_edge);
        logic prev_in1;
        done_edge     = -1;
        in1_toggles   = 0;
        in1_last_edge = -1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        prev_in1 = in1;
        for (int n = 1; n <= 200; n++) begin
            if (n == restart_at) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            if (in1 !== prev_in1) begin
                in1_toggles++;
                in1_last_edge = n;
                prev_in1 = in1;
            end
            if (done) begin
                done_edge = n;
                break;
            end
        end
        if (done_edge < 0) chk("sweep_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int de, tg, te, bad_rows, b_done_edge;
        mode  = 0;
        reset = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_observed", observed, 0);
        chk("rst_inputs", {in1, in2, in3}, 0);
        @(negedge clk);
        reset = 1'b0;

        // Ideal block, with the SETTLE=1 instance swept alongside.
        run_sweep(0, de, tg, te);
        chk("ideal_done_edge", de, 40);
        chk("ideal_observed", observed, 8'h60);
        chk("ideal_pass", pass, 1);
        chk("ideal_mm", mismatch_count, 0);
        chk("ideal_fail_valid", fail_valid, 0);
        chk("ideal_busy", busy, 0);
        chk("ideal_inputs_park", {in1, in2, in3}, 3'b111);
        chk("s1_observed", b_observed, 8'h60);
        chk("s1_pass", b_pass, 1);

        mode = 1;
        run_sweep(0, de, tg, te);
        chk("stuck0_observed", observed, 8'h00);
        chk("stuck0_pass", pass, 0);
        chk("stuck0_mm", mismatch_count, 2);
        chk("stuck0_fail_valid", fail_valid, 1);
        chk("stuck0_first", first_fail_row, 1);

        mode = 2;
        run_sweep(0, de, tg, te);
        chk("inv_observed", observed, 8'h9F);
        chk("inv_mm", mismatch_count, 8);
        chk("inv_first", first_fail_row, 0);
        chk("inv_pass", pass, 0);

        mode = 3;
        run_sweep(0, de, tg, te);
        chk("in1_observed", observed, 8'h0F);
        chk("in1_mm", mismatch_count, 6);
        chk("in1_toggles", tg, 1);
        chk("in1_toggle_edge", te, 20);

        mode = 0;
        run_sweep(12, de, tg, te);
        chk("restart_done_edge", de, 40);
        chk("restart_observed", observed, 8'h60);
        chk("restart_pass", pass, 1);

        // SETTLE=1: each row held 2 cycles, done at edge 16.
        bad_rows    = 0;
        b_done_edge = -1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if ({b_in1, b_in2, b_in3} !== 3'd0) bad_rows++;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (n < 16 && {b_in1, b_in2, b_in3} !== 3'(n / 2)) bad_rows++;
            if (b_done && b_done_edge < 0) b_done_edge = n;
        end
        chk("s1_row_hold", bad_rows, 0);
        chk("s1_done_edge", b_done_edge, 16);

        // Reset during row 3 (edges 15..19) with a failing block.
        mode = 1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        chk("pre_rst_row", {in1, in2, in3}, 3);
        chk("pre_rst_mm", mismatch_count, 2);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_observed", observed, 0);
        chk("midrst_mm", mismatch_count, 0);
        chk("midrst_fail_valid", fail_valid, 0);
        chk("midrst_inputs", {in1, in2, in3}, 0);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_idle", {busy, done}, 0);
        mode = 0;
        run_sweep(0, de, tg, te);
        chk("post_rst_done_edge", de, 40);
        chk("post_rst_pass", pass, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
